// File: rtl/rr_arbiter_wslice.sv
// Round-robin arbiter for N requesters; each grant lasts up to slice_cfg[k]+1 cycles.
// Optional ARB_LOCK_EN adds a per-channel lock input that holds the owner past expiry.
module rr_arbiter_wslice #(
  parameter  int N  = 4,
  parameter  int CW = 4,
  localparam int IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic [N*CW-1:0] slice_cfg,
`ifdef ARB_LOCK_EN
  input  logic [N-1:0]    lock,
`endif
  output logic [N-1:0]    gnt,
  output logic            gnt_valid,
  output logic [IW-1:0]   gnt_id,
  output logic            slice_exp
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          ptr_q, ptr_d;   // rotation pointer; equals the owner while in GRANT
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [N-1:0]           gnt_d;
  logic [IW-1:0]          gnt_id_d;
  logic                   exp_d;
  logic                   load;
  logic                   hold;
  logic                   others;
  logic [IW-1:0]          nxt;
  logic [N-1:0]           own_oh;
  logic [N-1:0][CW-1:0]   cfg;

  for (genvar k = 0; k < N; k++) begin : g_cfg
    assign cfg[k] = slice_cfg[k*CW +: CW];
  end

`ifdef ARB_LOCK_EN
  assign hold = lock[ptr_q];
`else
  assign hold = 1'b0;
`endif

  // First requester after p, wrapping round so p itself is considered last.
  function automatic logic [IW-1:0] next_of(input logic [IW-1:0] p, input logic [N-1:0] r);
    logic [IW-1:0] sel;
    logic [IW:0]   idx;
    logic          hit;
    sel = p;
    hit = 1'b0;
    for (int i = 1; i <= N; i++) begin
      idx = {1'b0, p} + (IW+1)'(i);
      if (idx >= (IW+1)'(N)) idx = idx - (IW+1)'(N);
      if (!hit && r[idx[IW-1:0]]) begin
        sel = idx[IW-1:0];
        hit = 1'b1;
      end
    end
    return sel;
  endfunction

  assign nxt    = next_of(ptr_q, req);
  assign own_oh = {{(N-1){1'b0}}, 1'b1} << ptr_q;
  assign others = |(req & ~own_oh);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    exp_d   = 1'b0;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (|req) begin
          ptr_d   = nxt;
          load    = 1'b1;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if (!req[ptr_q]) begin
          if (|req) begin
            ptr_d = nxt;
            load  = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else if (!hold) begin
          // Expired: hand over if anyone else waits, otherwise re-grant the same owner.
          load = 1'b1;
          if (others) begin
            ptr_d = nxt;
            exp_d = 1'b1;
          end
        end
      end
    endcase
    if (load) cnt_d = cfg[ptr_d];
    gnt_d    = (state_d == GRANT) ? ({{(N-1){1'b0}}, 1'b1} << ptr_d) : '0;
    gnt_id_d = (state_d == GRANT) ? ptr_d : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= IW'(N-1);
      cnt_q     <= '0;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      slice_exp <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      gnt       <= gnt_d;
      gnt_valid <= |gnt_d;
      gnt_id    <= gnt_id_d;
      slice_exp <= exp_d;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_wslice.sv
// Scoreboard bench for rr_arbiter_wslice: a slice-length model predicts each cycle's outputs,
// a negedge monitor pops and compares. Define ARB_LOCK_EN to exercise the lock input as well.
module tb_rr_arbiter_wslice;
  localparam int N  = 4;
  localparam int CW = 4;
  localparam int IW = $clog2(N);

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N*CW-1:0] slice_cfg = '0;
  logic [N-1:0]    lock = '0;
  logic [N-1:0]    gnt;
  logic            gnt_valid;
  logic [IW-1:0]   gnt_id;
  logic            slice_exp;

  always #5 clk = ~clk;

  rr_arbiter_wslice #(.N(N), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .slice_cfg (slice_cfg),
`ifdef ARB_LOCK_EN
    .lock      (lock),
`endif
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .slice_exp (slice_exp)
  );

  typedef struct packed {
    logic [N-1:0]  g;
    logic          v;
    logic [IW-1:0] id;
    logic          sx;
  } obs_t;

  obs_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Model: owner (-1 = none), cycles served so far in this slice, and slice length.
  int m_owner = -1;
  int m_last  = N-1;
  int m_el    = 0;
  int m_len   = 0;
  bit m_exp   = 1'b0;

  function automatic int pick(input int from, input logic [N-1:0] r);
    for (int i = 1; i <= N; i++) begin
      if (r[(from + i) % N]) return (from + i) % N;
    end
    return from;
  endfunction

  function automatic void m_start(input int o);
    logic [CW-1:0] f;
    f       = slice_cfg[o*CW +: CW];
    m_owner = o;
    m_last  = o;
    m_el    = 1;
    m_len   = int'(f) + 1;
  endfunction

  function automatic void m_reset();
    m_owner = -1;
    m_last  = N-1;
    m_el    = 0;
    m_len   = 0;
    m_exp   = 1'b0;
  endfunction

  function automatic void m_step();
    bit lk;
    m_exp = 1'b0;
    if (m_owner < 0) begin
      if (req != '0) m_start(pick(m_last, req));
    end else if (!req[m_owner]) begin
      if (req != '0) m_start(pick(m_owner, req));
      else m_owner = -1;
    end else if (m_el < m_len) begin
      m_el++;
    end else begin
      lk = 1'b0;
`ifdef ARB_LOCK_EN
      lk = lock[m_owner];
`endif
      if (!lk) begin
        if ((req & ~(N'(1) << m_owner)) != '0) begin
          m_start(pick(m_owner, req));
          m_exp = 1'b1;
        end else begin
          m_start(m_owner);
        end
      end
    end
  endfunction

  function automatic obs_t m_obs();
    obs_t o;
    o.g  = (m_owner >= 0) ? (N'(1) << m_owner) : '0;
    o.v  = (m_owner >= 0);
    o.id = (m_owner >= 0) ? IW'(m_owner) : '0;
    o.sx = m_exp;
    return o;
  endfunction

  // Advance the model on the inputs sampled at this edge, then apply new inputs.
  task automatic cyc(input logic [N-1:0] r, input logic [N*CW-1:0] c,
                     input logic [N-1:0] lk, input logic rs);
    @(posedge clk);
    #1;
    if (rst) m_reset();
    else m_step();
    rst       = rs;
    req       = r;
    slice_cfg = c;
    lock      = lk;
    if (rs) m_reset();
    sb_q.push_back(m_obs());
  endtask

  function automatic logic [N*CW-1:0] mk(input int c3, input int c2, input int c1, input int c0);
    return {CW'(c3), CW'(c2), CW'(c1), CW'(c0)};
  endfunction

  initial begin
    obs_t e, got;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        got = {gnt, gnt_valid, gnt_id, slice_exp};
        checks++;
        if (got !== e) begin
          failures++;
          $display("FAIL outputs t=%0t got gnt=%b v=%b id=%0d exp=%b want gnt=%b v=%b id=%0d exp=%b",
                   $time, got.g, got.v, got.id, got.sx, e.g, e.v, e.id, e.sx);
        end
        checks++;
        if (!$onehot0(gnt)) begin
          failures++;
          $display("FAIL onehot0 t=%0t got gnt=%b want at most one bit", $time, gnt);
        end
      end
    end
  end

  initial begin
    logic [N-1:0]    r, l;
    logic [N*CW-1:0] c;
    logic            rs;

    // reset with everyone requesting, then release
    repeat (3) cyc(4'b1111, mk(0, 0, 0, 0), '0, 1'b1);
    repeat (4) cyc(4'b1111, mk(0, 0, 0, 0), '0, 1'b0);

    // single steady requester: continuous grant, no expiry pulses
    cyc(4'b0000, mk(0, 0, 0, 2), '0, 1'b1);
    repeat (12) cyc(4'b0001, mk(0, 0, 0, 2), '0, 1'b0);

    // all requesting with distinct slices
    cyc(4'b0000, mk(3, 2, 1, 0), '0, 1'b1);
    repeat (25) cyc(4'b1111, mk(3, 2, 1, 0), '0, 1'b0);

    // early release of ch0 mid-slice
    cyc(4'b0000, mk(0, 0, 0, 5), '0, 1'b1);
    repeat (3) cyc(4'b0011, mk(0, 0, 0, 5), '0, 1'b0);
    repeat (4) cyc(4'b0010, mk(0, 0, 0, 5), '0, 1'b0);

    // reset while ch2 owns mid-slice, restart from channel 0 scan
    cyc(4'b0000, mk(0, 7, 0, 0), '0, 1'b1);
    repeat (4) cyc(4'b0100, mk(0, 7, 0, 0), '0, 1'b0);
    cyc(4'b1100, mk(0, 7, 0, 0), '0, 1'b1);
    repeat (6) cyc(4'b1100, mk(0, 7, 0, 0), '0, 1'b0);

    // all-ones slice and zero slice boundary
    cyc(4'b0000, mk(0, 0, 0, 15), '0, 1'b1);
    repeat (20) cyc(4'b0011, mk(0, 0, 0, 15), '0, 1'b0);

`ifdef ARB_LOCK_EN
    cyc(4'b0000, mk(0, 0, 0, 1), '0, 1'b1);
    repeat (8) cyc(4'b0011, mk(0, 0, 0, 1), 4'b0001, 1'b0);
    repeat (4) cyc(4'b0011, mk(0, 0, 0, 1), 4'b0000, 1'b0);
`endif

    // randomized traffic, config, lock and occasional reset
    for (int i = 0; i < 800; i++) begin
      r  = N'($urandom);
      if (i % 4 == 0) r = r | N'($urandom);
      c  = (N*CW)'($urandom);
      if (i % 3 != 0) c = c & mk(3, 3, 3, 3);
      l  = N'($urandom) & N'($urandom);
      rs = ($urandom_range(0, 99) == 0);
      if ((i / 40) % 2 == 1) r = req | N'($urandom_range(0, 1) << $urandom_range(0, N-1));
      cyc(r, c, l, rs);
    end

    cyc('0, '0, '0, 1'b0);
    @(negedge clk);
    #1;
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d pending entries want 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
